detector_tono: RTL
==================

DETECTOR_TONO -- requirements
Module: detector_tono

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- CLK_HZ, 50_000_000, system clock frequency; documentation only.
- TIMEOUT, 250_000, cycles without a rising edge before the tone is declared absent.
- TOL_SHIFT, 6, match tolerance equals nominal >> TOL_SHIFT, about 1.56 %.
- STABLE_N, 2, consecutive matching periods required for lock.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single system clock; all logic on its rising edge.
- rst_n, in, 1, reset; synchronous and active-low.
- melody_in, in, 1, asynchronous square-wave tone input, as driven onto the buzzer line.
- enable, in, 1, high = measure; low = hold idle.
- period, out, 20, last measured full period in clk cycles.
- note_code, out, 4, classified note.
- note_valid, out, 1, high while a note is locked.
- tone_present, out, 1, high while edges arrive within TIMEOUT.
- new_period, out, 1, one-cycle pulse when period updates.

Function
REQ-003 melody_in SHALL pass through a 2-flop synchronizer, then a third flop for rising-edge detection; edge_det = sync2 & ~sync3.

REQ-004 Counter cnt (20 bit) SHALL increment every enabled cycle and saturate at TIMEOUT.
- On edge_det, cnt loads 1.

REQ-005 The FSM SHALL have three states: IDLE, MEASURE, LOCKED.
- IDLE -> MEASURE on the first edge_det.
- MEASURE -> LOCKED when STABLE_N consecutive periods share one code in 1..7.
- LOCKED -> MEASURE when a period's code differs from the locked code.
- Any state -> IDLE when cnt reaches TIMEOUT.

REQ-006 On edge_det in MEASURE or LOCKED, the block SHALL, on the next clock edge:
- set period <= cnt;
- pulse new_period for exactly one cycle;
- set note_code <= classify(cnt).

REQ-007 classify(p) SHALL return the first code in the table below for which |p - nominal| <= nominal >> TOL_SHIFT; if no entry matches it returns 15 (unknown). Nominal full periods at 50 MHz:
- 1 do = 180_388
- 2 re = 160_708
- 3 fa = 135_140
- 4 sol = 120_396
- 5 fa1 = 67_570
- 6 fa2 = 71_588
- 7 do1 = 90_196

REQ-008 Classification arithmetic SHALL be unsigned 20-bit, with the absolute difference computed without wrap. Nominal windows SHALL NOT overlap at the default TOL_SHIFT.

REQ-009 The first edge_det out of IDLE SHALL only start counting. It SHALL NOT update period or note_code, and SHALL NOT pulse new_period.

REQ-010 Stability counting:
- A stability counter increments when the new code equals the previous code and is in 1..7.
- It loads 1 when the code differs.
- It loads 0 when the code is 15.
- note_valid = (state == LOCKED).

REQ-011 tone_present SHALL be high in MEASURE and LOCKED, and low in IDLE.

REQ-012 On timeout entry to IDLE, the block SHALL clear note_code to 0 and note_valid to 0. period SHALL retain its last value.

REQ-013 When edge_det coincides with cnt reaching TIMEOUT, the edge SHALL win: the block reloads cnt = 1 and does not enter IDLE.

REQ-014 When enable is low:
- state is forced to IDLE and cnt to 0;
- all outputs except period take their reset values;
- the synchronizer keeps running.

REQ-015 In LOCKED, a period with code 15 SHALL drop lock to MEASURE on the same update.

Reset
REQ-016 When rst_n is low at a clk edge, the block SHALL reset the following, regardless of state or enable:
- state = IDLE;
- cnt, stability counter, period = 0;
- note_code = 0;
- note_valid, tone_present, new_period = 0;
- synchronizer flops = 0.

REQ-017 Reset asserted mid-period SHALL discard any partial measurement. The first edge after release SHALL be treated as in REQ-009.

Verification
REQ-018 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Square wave, half-period 60_198 cycles, for 3 periods -> period = 120_396, note_code = 4; note_valid rises on the 2nd new_period; tone_present is high.
- do1 tone (90_196 period) switched to fa1 (67_570) mid-stream -> LOCKED -> MEASURE at the first fa1 period; note_code = 5; LOCKED again one period later.
- Period 100_000 (no match) -> note_code = 15; note_valid = 0; state remains MEASURE.
- Input stops high after lock -> exactly TIMEOUT cycles after the last edge: tone_present = 0, note_code = 0, note_valid = 0; period is held.
- rst_n pulsed low for 1 cycle while locked on fa (135_140) -> all outputs 0 on the next cycle; the first post-reset edge produces no new_period; the second edge gives period = 135_140.
- Edge arriving on the exact cycle cnt reaches TIMEOUT -> no IDLE entry; period = TIMEOUT; new_period pulses.

Source files
------------

// File: rtl/detector_tono.sv
// Tone detector: measures the full period of a buzzer square wave, classifies it
// against a fixed note table and locks once the same note repeats STABLE_N times.
module detector_tono #(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned TIMEOUT   = 250_000,
  parameter int unsigned TOL_SHIFT = 6,
  parameter int unsigned STABLE_N  = 2,
  // Right shift applied to the 50 MHz note table, for slower clocks.
  parameter int unsigned NOM_SHIFT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        melody_in,
  input  logic        enable,
  output logic [19:0] period,
  output logic [3:0]  note_code,
  output logic        note_valid,
  output logic        tone_present,
  output logic        new_period
);

  localparam int unsigned CNT_W  = 20;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned STAB_W = (STABLE_N < 2) ? 1 : $clog2(STABLE_N + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_N);
  localparam logic [CODE_W-1:0] CODE_UNK = CODE_W'(15);

  // Nominal full periods at 50 MHz: do, re, fa, sol, fa1, fa2, do1.
  localparam logic [CNT_W-1:0] NOM_TAB [7] = '{
    20'd180_388, 20'd160_708, 20'd135_140, 20'd120_396,
    20'd67_570,  20'd71_588,  20'd90_196
  };

  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

  state_t              state;
  logic [2:0]          sync;
  logic [CNT_W-1:0]    cnt;
  logic [STAB_W-1:0]   stab;
  logic                edge_det_c;
  logic [CODE_W-1:0]   code_c;
  logic                code_ok_c;
  logic [STAB_W-1:0]   stab_nxt_c;
  logic                unused_clk_hz;

  assign unused_clk_hz = ^32'(CLK_HZ);

  // Lowest table index wins, so scan downwards and let earlier entries overwrite.
  function automatic logic [CODE_W-1:0] classify(input logic [CNT_W-1:0] p);
    logic [CNT_W-1:0] nom;
    logic [CNT_W-1:0] tol;
    logic [CNT_W-1:0] diff;
    classify = CODE_UNK;
    for (int i = 6; i >= 0; i--) begin
      nom  = NOM_TAB[i] >> NOM_SHIFT;
      tol  = nom >> TOL_SHIFT;
      diff = (p >= nom) ? (p - nom) : (nom - p);
      if (diff <= tol) classify = CODE_W'(i + 1);
    end
  endfunction

  assign edge_det_c = sync[1] & ~sync[2];
  assign code_c     = classify(cnt);
  assign code_ok_c  = (code_c != CODE_UNK);

  // Run length of identical valid codes, compared against the previous reported code.
  always_comb begin
    stab_nxt_c = '0;
    if (!code_ok_c)
      stab_nxt_c = '0;
    else if (code_c != note_code)
      stab_nxt_c = STAB_W'(1);
    else if (stab != STAB_MAX)
      stab_nxt_c = stab + 1'b1;
    else
      stab_nxt_c = stab;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync         <= '0;
      state        <= IDLE;
      cnt          <= '0;
      stab         <= '0;
      period       <= '0;
      note_code    <= '0;
      note_valid   <= 1'b0;
      tone_present <= 1'b0;
      new_period   <= 1'b0;
    end else begin
      sync       <= {sync[1:0], melody_in};
      new_period <= 1'b0;
      if (!enable) begin
        state        <= IDLE;
        cnt          <= '0;
        stab         <= '0;
        note_code    <= '0;
        note_valid   <= 1'b0;
        tone_present <= 1'b0;
      end else if (edge_det_c) begin
        // An edge always wins over a simultaneous timeout.
        cnt          <= CNT_W'(1);
        tone_present <= 1'b1;
        if (state == IDLE) begin
          state <= MEASURE;
        end else begin
          period     <= cnt;
          new_period <= 1'b1;
          note_code  <= code_c;
          stab       <= stab_nxt_c;
          if (state == LOCKED) begin
            if (code_c != note_code) begin
              state      <= MEASURE;
              note_valid <= 1'b0;
            end
          end else if (code_ok_c && (stab_nxt_c >= STAB_MAX)) begin
            state      <= LOCKED;
            note_valid <= 1'b1;
          end
        end
      end else if (cnt >= CNT_MAX) begin
        state        <= IDLE;
        stab         <= '0;
        note_code    <= '0;
        note_valid   <= 1'b0;
        tone_present <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
